// File: rtl/ioctl_loader.sv
// ioctl_loader: turns a host byte stream (valid/ready) into the MiSTer-style
// ioctl download bus. ioctl_download is held high for a setup window before
// the first write and a tail window after the last one, because the soc is
// kept in reset while it is high. ioctl_wait stalls the write strobe.
module ioctl_loader #(
    parameter int ADDR_W       = 25,
    parameter int SETUP_CYCLES = 4,
    parameter int WR_GAP       = 1,
    parameter int TAIL_CYCLES  = 4
) (
    input  logic              clk_sys,
    input  logic              reset_n,
    input  logic              start,
    input  logic              abort,
    input  logic [7:0]        index,
    input  logic [ADDR_W-1:0] length,
    input  logic              s_valid,
    input  logic [7:0]        s_data,
    output logic              s_ready,
    output logic              ioctl_download,
    output logic              ioctl_wr,
    output logic [ADDR_W-1:0] ioctl_addr,
    output logic [7:0]        ioctl_dout,
    output logic [7:0]        ioctl_index,
    input  logic              ioctl_wait,
    output logic              busy,
    output logic              done,
    output logic              aborted
);

    typedef enum logic [2:0] {
        IDLE,
        SETUP,
        FETCH,
        WRITE,
        GAP,
        TAIL
    } state_t;

    state_t            state, state_d;
    logic [7:0]        cnt, cnt_d;
    logic [ADDR_W-1:0] len_q, len_d;
    logic [ADDR_W-1:0] addr_d;
    logic [7:0]        dout_d, index_d;
    logic              download_d, wr_d, busy_d, done_d, aborted_d;

    // The only combinational output: a byte is taken exactly while fetching.
    assign s_ready = (state == FETCH);

    // State and all registered outputs; reset clears everything immediately.
    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) begin
            state          <= IDLE;
            cnt            <= '0;
            len_q          <= '0;
            ioctl_addr     <= '0;
            ioctl_dout     <= '0;
            ioctl_index    <= '0;
            ioctl_download <= 1'b0;
            ioctl_wr       <= 1'b0;
            busy           <= 1'b0;
            done           <= 1'b0;
            aborted        <= 1'b0;
        end else begin
            state          <= state_d;
            cnt            <= cnt_d;
            len_q          <= len_d;
            ioctl_addr     <= addr_d;
            ioctl_dout     <= dout_d;
            ioctl_index    <= index_d;
            ioctl_download <= download_d;
            ioctl_wr       <= wr_d;
            busy           <= busy_d;
            done           <= done_d;
            aborted        <= aborted_d;
        end
    end

    // Next-state and next-output logic. WRITE spans two phases: waiting for
    // ioctl_wait to drop (wr low), then the single strobe cycle (wr high),
    // at whose end the address advances and the sequencer moves on.
    always_comb begin
        state_d    = state;
        cnt_d      = cnt;
        len_d      = len_q;
        addr_d     = ioctl_addr;
        dout_d     = ioctl_dout;
        index_d    = ioctl_index;
        download_d = ioctl_download;
        wr_d       = 1'b0;
        done_d     = 1'b0;
        aborted_d  = aborted;

        if (state != IDLE && abort) begin
            state_d    = IDLE;
            download_d = 1'b0;
            aborted_d  = 1'b1;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        aborted_d = 1'b0;
                        if (length == '0) begin
                            done_d = 1'b1;
                        end else begin
                            len_d      = length;
                            index_d    = index;
                            addr_d     = '0;
                            cnt_d      = 8'(SETUP_CYCLES - 1);
                            download_d = 1'b1;
                            state_d    = SETUP;
                        end
                    end
                end
                SETUP: begin
                    if (cnt == 8'd0) state_d = FETCH;
                    else             cnt_d   = cnt - 8'd1;
                end
                FETCH: begin
                    if (s_valid) begin
                        dout_d  = s_data;
                        state_d = WRITE;
                    end
                end
                WRITE: begin
                    if (ioctl_wr) begin
                        if (ioctl_addr == len_q - ADDR_W'(1)) begin
                            cnt_d   = 8'(TAIL_CYCLES - 1);
                            state_d = TAIL;
                        end else begin
                            addr_d = ioctl_addr + ADDR_W'(1);
                            if (WR_GAP == 0) begin
                                state_d = FETCH;
                            end else begin
                                cnt_d   = 8'(WR_GAP - 1);
                                state_d = GAP;
                            end
                        end
                    end else if (!ioctl_wait) begin
                        wr_d = 1'b1;
                    end
                end
                GAP: begin
                    if (cnt == 8'd0) state_d = FETCH;
                    else             cnt_d   = cnt - 8'd1;
                end
                TAIL: begin
                    if (cnt == 8'd0) begin
                        download_d = 1'b0;
                        done_d     = 1'b1;
                        state_d    = IDLE;
                    end else begin
                        cnt_d = cnt - 8'd1;
                    end
                end
                default: begin
                    download_d = 1'b0;
                    state_d    = IDLE;
                end
            endcase
        end

        busy_d = (state_d != IDLE);
    end

endmodule

// File: tb/tb_ioctl_loader.sv
// Directed bench for ioctl_loader. A per-cycle check compares the bus with
// a model of the transfer (k-th write goes to address k carrying the k-th
// stream byte, only the expected number of writes, no strobe after a wait
// cycle), and each scenario pins cycle timing with hand-computed offsets.
module tb_ioctl_loader;

    localparam int AW = 25;

    logic          clk_sys = 1'b0;
    logic          reset_n, start, abort, s_valid, ioctl_wait;
    logic [7:0]    index, s_data;
    logic [AW-1:0] length;
    logic          s_ready, ioctl_download, ioctl_wr, busy, done, aborted;
    logic [AW-1:0] ioctl_addr;
    logic [7:0]    ioctl_dout, ioctl_index;

    ioctl_loader #(
        .ADDR_W      (AW),
        .SETUP_CYCLES(4),
        .WR_GAP      (1),
        .TAIL_CYCLES (4)
    ) dut (
        .clk_sys       (clk_sys),
        .reset_n       (reset_n),
        .start         (start),
        .abort         (abort),
        .index         (index),
        .length        (length),
        .s_valid       (s_valid),
        .s_data        (s_data),
        .s_ready       (s_ready),
        .ioctl_download(ioctl_download),
        .ioctl_wr      (ioctl_wr),
        .ioctl_addr    (ioctl_addr),
        .ioctl_dout    (ioctl_dout),
        .ioctl_index   (ioctl_index),
        .ioctl_wait    (ioctl_wait),
        .busy          (busy),
        .done          (done),
        .aborted       (aborted)
    );

    always #5 clk_sys = ~clk_sys;

    int cyc = 0;
    always @(posedge clk_sys) cyc <= cyc + 1;

    // Stream byte k of a transfer.
    function automatic logic [7:0] exp_byte(input int unsigned k);
        return 8'h5A ^ 8'(k * 37);
    endfunction

    // Host source: position advances on each handshake, restarts per transfer.
    int unsigned acc_n = 0;
    logic        clr_acc = 1'b0;
    always @(posedge clk_sys) begin
        if (clr_acc)                acc_n <= 0;
        else if (s_valid && s_ready) acc_n <= acc_n + 1;
    end
    assign s_data = exp_byte(acc_n);

    int total = 0;
    int bad   = 0;

    // Model state and event records.
    int         m_len = 0;
    int         m_n   = 0;
    logic [7:0] m_index = '0;
    logic       prev_wait = 1'b0;
    logic       prev_dl   = 1'b0;
    bit         chk_en    = 1'b0;
    int         wr_cyc[$];
    logic [7:0] wr_dat[$];
    int         done_cyc[$];
    int         rise_cnt = 0;
    int         last_rise = 0;
    int         last_fall = 0;
    int         t0, wr_base, done_base, rise_base;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Every-cycle comparison against the transfer model.
    task automatic cycle_check();
        if (chk_en) begin
            chk("busy_eq_download", 64'(busy), 64'(ioctl_download));
            if (!ioctl_download) begin
                chk("wr_without_download", 64'(ioctl_wr), 64'd0);
                chk("ready_without_download", 64'(s_ready), 64'd0);
            end
            if (ioctl_wr) begin
                chk("wr_after_wait", 64'(prev_wait), 64'd0);
                chk("wr_addr", 64'(ioctl_addr), 64'(m_n));
                chk("wr_dout", 64'(ioctl_dout), 64'(exp_byte(m_n)));
                chk("wr_index", 64'(ioctl_index), 64'(m_index));
                chk("wr_not_extra", 64'(m_n < m_len), 64'd1);
                wr_cyc.push_back(cyc);
                wr_dat.push_back(ioctl_dout);
                m_n++;
            end
            if (done) begin
                chk("done_after_all_writes", 64'(m_n), 64'(m_len));
                chk("done_download_low", 64'(ioctl_download), 64'd0);
                done_cyc.push_back(cyc);
            end
            if (ioctl_download && !prev_dl) begin
                rise_cnt++;
                last_rise = cyc;
            end
            if (!ioctl_download && prev_dl) last_fall = cyc;
        end
        prev_wait = ioctl_wait;
        prev_dl   = ioctl_download;
    endtask

    task automatic tick();
        @(negedge clk_sys);
        cycle_check();
        @(posedge clk_sys);
        #1;
    endtask

    task automatic begin_xfer(input int len, input logic [7:0] idx);
        m_len     = len;
        m_n       = 0;
        m_index   = idx;
        length    = AW'(len);
        index     = idx;
        start     = 1'b1;
        clr_acc   = 1'b1;
        t0        = cyc;
        wr_base   = wr_cyc.size();
        done_base = done_cyc.size();
        rise_base = rise_cnt;
        tick();
        start   = 1'b0;
        clr_acc = 1'b0;
    endtask

    task automatic wait_done(input int budget);
        int n = 0;
        while (done_cyc.size() == done_base && n < budget) begin
            tick();
            n++;
        end
        chk("done_within_budget", 64'(done_cyc.size() > done_base), 64'd1);
    endtask

    task automatic check_all_zero(input string tag);
        chk({tag, "_download"}, 64'(ioctl_download), 64'd0);
        chk({tag, "_wr"},       64'(ioctl_wr),       64'd0);
        chk({tag, "_addr"},     64'(ioctl_addr),     64'd0);
        chk({tag, "_dout"},     64'(ioctl_dout),     64'd0);
        chk({tag, "_index"},    64'(ioctl_index),    64'd0);
        chk({tag, "_busy"},     64'(busy),           64'd0);
        chk({tag, "_done"},     64'(done),           64'd0);
        chk({tag, "_aborted"},  64'(aborted),        64'd0);
        chk({tag, "_s_ready"},  64'(s_ready),        64'd0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        reset_n = 1'b0; start = 1'b0; abort = 1'b0; s_valid = 1'b0;
        ioctl_wait = 1'b0; index = '0; length = '0;
        repeat (3) @(posedge clk_sys);
        #1;
        check_all_zero("reset");
        reset_n = 1'b1;
        tick();
        chk_en = 1'b1;

        // 1: plain 3-byte transfer.
        s_valid = 1'b1;
        begin_xfer(3, 8'h01);
        chk("t1_busy", 64'(busy), 64'd1);
        wait_done(60);
        chk("t1_rise",  64'(last_rise - t0), 64'd1);
        chk("t1_nwr",   64'(wr_cyc.size() - wr_base), 64'd3);
        chk("t1_wr0",   64'(wr_cyc[wr_base]     - t0), 64'd7);
        chk("t1_wr1",   64'(wr_cyc[wr_base + 1] - t0), 64'd11);
        chk("t1_wr2",   64'(wr_cyc[wr_base + 2] - t0), 64'd15);
        chk("t1_d0",    64'(wr_dat[wr_base]),     64'h5A);
        chk("t1_d1",    64'(wr_dat[wr_base + 1]), 64'h7F);
        chk("t1_d2",    64'(wr_dat[wr_base + 2]), 64'h10);
        chk("t1_done",  64'(done_cyc[done_base] - t0), 64'd20);
        chk("t1_fall",  64'(last_fall - t0), 64'd20);
        chk("t1_addr_hold", 64'(ioctl_addr), 64'd2);
        chk("t1_index", 64'(ioctl_index), 64'h01);
        repeat (3) tick();

        // 2: ioctl_wait held 5 cycles while byte 1 waits in WRITE.
        begin_xfer(3, 8'h22);
        while (cyc < t0 + 10) tick();
        ioctl_wait = 1'b1;
        for (int i = 0; i < 5; i++) begin
            chk("t2_stall_addr", 64'(ioctl_addr), 64'd1);
            chk("t2_stall_dout", 64'(ioctl_dout), 64'h7F);
            chk("t2_stall_wr",   64'(ioctl_wr),   64'd0);
            tick();
        end
        ioctl_wait = 1'b0;
        wait_done(60);
        chk("t2_wr0",  64'(wr_cyc[wr_base]     - t0), 64'd7);
        chk("t2_wr1",  64'(wr_cyc[wr_base + 1] - t0), 64'd16);
        chk("t2_wr2",  64'(wr_cyc[wr_base + 2] - t0), 64'd20);
        chk("t2_done", 64'(done_cyc[done_base] - t0), 64'd25);
        repeat (3) tick();

        // 3: source starves for 10 cycles before byte 2.
        begin_xfer(4, 8'h33);
        while (cyc < t0 + 12) tick();
        s_valid = 1'b0;
        for (int i = 0; i < 10; i++) begin
            if (cyc >= t0 + 13) begin
                chk("t3_ready_held", 64'(s_ready), 64'd1);
                chk("t3_download",   64'(ioctl_download), 64'd1);
            end
            chk("t3_no_wr", 64'(ioctl_wr), 64'd0);
            tick();
        end
        s_valid = 1'b1;
        wait_done(80);
        chk("t3_nwr",  64'(wr_cyc.size() - wr_base), 64'd4);
        chk("t3_wr2",  64'(wr_cyc[wr_base + 2] - t0), 64'd24);
        chk("t3_wr3",  64'(wr_cyc[wr_base + 3] - t0), 64'd28);
        chk("t3_done", 64'(done_cyc[done_base] - t0), 64'd33);
        repeat (3) tick();

        // 4: abort in GAP after the second write of 5, then restart with
        //    start+abort together, plus an ignored mid-transfer start.
        begin_xfer(5, 8'h44);
        while (cyc < t0 + 12) tick();
        abort = 1'b1;
        tick();
        abort = 1'b0;
        m_len = m_n;
        chk("t4_download", 64'(ioctl_download), 64'd0);
        chk("t4_busy",     64'(busy),           64'd0);
        chk("t4_aborted",  64'(aborted),        64'd1);
        chk("t4_nwr",      64'(wr_cyc.size() - wr_base), 64'd2);
        repeat (20) tick();
        chk("t4_no_done",  64'(done_cyc.size() - done_base), 64'd0);
        chk("t4_sticky",   64'(aborted), 64'd1);
        abort = 1'b1;
        begin_xfer(2, 8'h55);
        abort = 1'b0;
        chk("t4_aborted_clr", 64'(aborted), 64'd0);
        chk("t4_restart_dl",  64'(ioctl_download), 64'd1);
        while (cyc < t0 + 8) tick();
        start  = 1'b1;
        length = AW'(7);
        tick();
        start  = 1'b0;
        length = AW'(2);
        wait_done(60);
        chk("t4_r_nwr",  64'(wr_cyc.size() - wr_base), 64'd2);
        chk("t4_r_done", 64'(done_cyc[done_base] - t0), 64'd16);
        chk("t4_r_abrt", 64'(aborted), 64'd0);
        repeat (3) tick();

        // 5: zero-length request.
        begin_xfer(0, 8'h66);
        repeat (10) tick();
        chk("t5_done",  64'(done_cyc[done_base] - t0), 64'd1);
        chk("t5_ndone", 64'(done_cyc.size() - done_base), 64'd1);
        chk("t5_nrise", 64'(rise_cnt - rise_base), 64'd0);
        chk("t5_nwr",   64'(wr_cyc.size() - wr_base), 64'd0);
        chk("t5_index", 64'(ioctl_index), 64'h55);

        // 6: asynchronous reset while stalled in WRITE.
        ioctl_wait = 1'b1;
        begin_xfer(3, 8'h77);
        while (cyc < t0 + 6) tick();
        chk("t6_pre_dl", 64'(ioctl_download), 64'd1);
        #2;
        chk_en  = 1'b0;
        reset_n = 1'b0;
        #1;
        chk("t6_async_dl",   64'(ioctl_download), 64'd0);
        chk("t6_async_wr",   64'(ioctl_wr),       64'd0);
        chk("t6_async_busy", 64'(busy),           64'd0);
        ioctl_wait = 1'b0;
        m_len = 0;
        m_n   = 0;
        tick();
        tick();
        reset_n = 1'b1;
        tick();
        check_all_zero("t6_after");
        chk("t6_no_done", 64'(done_cyc.size() - done_base), 64'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
